// File: rtl/bist_seq_ctrl.sv
// bist_seq_ctrl: sequencer for one SPI BIST run.
// Clears TPG/ORA, steps PAT_CNT patterns, flushes LAT cycles of CUT latency
// into the ORA, then compares the signature against the golden value latched
// at start. All outputs are registered and decoded from the next state, so
// they change on the same edge the FSM enters a state.
module bist_seq_ctrl #(
  parameter int SIG_W   = 4,
  parameter int PAT_CNT = 15,
  parameter int LAT     = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic [SIG_W-1:0] signature_in,
  output logic             tpg_clear,
  output logic             tpg_en,
  output logic             ora_clear,
  output logic             ora_en,
  output logic             bist_mode,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic [CNT_W-1:0] pattern_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_COMPARE, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PAT_CNT);
  localparam logic [3:0]       LAT_N    = 4'(LAT);
  localparam bit               NO_FLUSH = (LAT == 0);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       flush_q, flush_d;
  logic             pass_d, aborted_d;

  // Next-state, latched golden, counters and result flags.
  always_comb begin
    state_d   = state_q;
    golden_d  = golden_q;
    cnt_d     = pattern_cnt;
    flush_d   = '0;
    pass_d    = pass;
    aborted_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // abort wins over start in IDLE and produces no aborted pulse
        if (start && !abort) begin
          state_d  = S_CLEAR;
          golden_d = golden_sig;
          pass_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      S_CLEAR:   state_d = S_RUN;
      S_RUN: begin
        // pattern_cnt already counts the pattern applied in this cycle
        if (pattern_cnt == PAT_LAST) state_d = NO_FLUSH ? S_COMPARE : S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_q == LAT_N) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        state_d = S_DONE;
        pass_d  = (signature_in == golden_q);
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // DONE is already committed: the run completes even if abort arrives
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      pass_d    = 1'b0;
    end
    if (state_d == S_RUN)   cnt_d   = pattern_cnt + 1'b1;
    if (state_d == S_FLUSH) flush_d = flush_q + 4'd1;
  end

  // State, latches and registered output decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      golden_q    <= '0;
      flush_q     <= '0;
      pattern_cnt <= '0;
      pass        <= 1'b0;
      aborted     <= 1'b0;
      tpg_clear   <= 1'b0;
      ora_clear   <= 1'b0;
      tpg_en      <= 1'b0;
      ora_en      <= 1'b0;
      bist_mode   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      golden_q    <= golden_d;
      flush_q     <= flush_d;
      pattern_cnt <= cnt_d;
      pass        <= pass_d;
      aborted     <= aborted_d;
      tpg_clear   <= (state_d == S_CLEAR);
      ora_clear   <= (state_d == S_CLEAR);
      tpg_en      <= (state_d == S_RUN);
      ora_en      <= (state_d == S_RUN) || (state_d == S_FLUSH);
      bist_mode   <= (state_d != S_IDLE);
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
    end
  end

endmodule
